key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles before a level change is accepted (20 ms at 50 MHz).
REQ-003 SHALL have parameter LONG_CYCLES, default 50_000_000, held-pressed cycles before a long-press pulse (1 s at 50 MHz).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port key, input, N_KEYS, raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 SHALL have port key_level, output, N_KEYS, debounced state, active-high (1 = pressed).
REQ-008 SHALL have port key_press, output, N_KEYS, one-cycle pulse on accepted press.
REQ-009 SHALL have port key_release, output, N_KEYS, one-cycle pulse on accepted release.
REQ-010 SHALL have port key_long, output, N_KEYS, one-cycle pulse on long-press threshold.

Function
REQ-011 SHALL pass each key bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL compare, per channel, the synchronized input against the accepted level; when equal, the channel stability counter is cleared to 0.
REQ-013 SHALL increment the stability counter on each cycle the synchronized input differs from the accepted level.
REQ-014 SHALL, once the input has differed for DEBOUNCE_CYCLES consecutive cycles, update the accepted level, clear the counter and pulse key_press or key_release for exactly one cycle, in the same cycle key_level changes.
REQ-015 SHALL restart the count from 0 on any bounce back to the accepted level, so a glitch shorter than DEBOUNCE_CYCLES produces no output change.
REQ-016 SHALL have a total latency of 2 + DEBOUNCE_CYCLES clocks from a clean pin edge to the key_level and pulse output.
REQ-017 SHALL size each stability counter to $clog2(DEBOUNCE_CYCLES+1) bits; the counter never wraps.
REQ-018 SHALL treat channels fully independently; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-019 SHALL register all outputs; no combinational path exists from key to any output.

Reset
REQ-020 SHALL, on rst high, force synchronizer flops to 1 (released) and the accepted level to released.
REQ-021 SHALL, on rst high, clear all counters to 0 and drive key_level, key_press, key_release and key_long to 0.
REQ-022 SHALL, when rst asserts mid-count, discard the count; after release a held key needs a full 2 + DEBOUNCE_CYCLES before key_press.

Configuration
REQ-023 SHALL, with macro KEY_LONGPRESS_EN defined, keep a per-channel hold counter that counts while key_level is 1, saturates, and clears on release.
REQ-024 SHALL pulse key_long once per press, when the hold counter reaches LONG_CYCLES; no repeat until a release is accepted.
REQ-025 SHALL, with KEY_LONGPRESS_EN undefined, omit the hold counters and tie key_long to constant 0; the port list is unchanged.

Structure
REQ-026 SHALL place the released-level constant (1'b1) and the default cycle counts in the shared package key_pkg.
REQ-027 SHALL implement one channel in sub-module key_debounce_ch and instantiate it N_KEYS times in a generate loop.

Verification
(bench parameters: DEBOUNCE_CYCLES=16, LONG_CYCLES=64)
REQ-028 SHALL check a clean press: key[0] goes 1->0 and holds -> key_press[0] high exactly one cycle, 18 clocks after the edge; key_level[0]=1.
REQ-029 SHALL check bounce rejection: key[1] toggles low for 10 cycles then high, repeated 5 times -> key_level[1] stays 0 and no pulses occur.
REQ-030 SHALL check release: after an accepted press, key[0] goes 0->1 -> key_release[0] one cycle at +18; key_level[0]=0.
REQ-031 SHALL check simultaneous events: key[3:0]=0000 applied together -> key_press=4'b1111 in a single cycle.
REQ-032 SHALL check reset mid-count: rst pulsed 8 cycles into a press -> outputs 0; key_press appears 18 clocks after rst falls.
REQ-033 SHALL check long press (KEY_LONGPRESS_EN defined): key[2] held 200 cycles -> exactly one key_long[2] pulse, 64 cycles after key_press[2]; with the macro undefined key_long stays 0.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared constants for the key debouncer.
// Raw pins are active-low, so the released level is 1'b1.
// The default cycle counts assume a 50 MHz clock (20 ms debounce, 1 s long press).
package key_pkg;

    localparam logic KEY_RELEASED = 1'b1;
    localparam logic KEY_PRESSED  = 1'b0;

    localparam int DEFAULT_N_KEYS          = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_LONG_CYCLES     = 50_000_000;

    // Width of a counter that must hold every value from 0 up to max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key pins and the debounced outputs of key_debounce.
// master drives the raw pins, slave (the debouncer) drives the outputs.
interface key_debounce_if
    import key_pkg::*;
#(
    parameter int N_KEYS = DEFAULT_N_KEYS
);

    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    modport master (
        output key,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one debounce channel.
// Synchronizes an active-low pin, accepts a level change only after the
// synchronized value has differed from the accepted level for DEBOUNCE_CYCLES
// consecutive clocks, and emits one-cycle press/release pulses.
// With KEY_LONGPRESS_EN defined a hold timer also emits a one-cycle long-press
// pulse LONG_CYCLES clocks after the press was accepted.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pin,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          acc_r;      // accepted raw level (active-low)
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic [CW-1:0] cnt_r;
    logic          differ_s;
    logic          accept_s;

    // Two-flop synchronizer; idles at the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= KEY_RELEASED;
            sync2_r <= KEY_RELEASED;
        end else begin
            sync1_r <= key_pin;
            sync2_r <= sync1_r;
        end
    end

    // The count reaching DEBOUNCE_CYCLES-1 while still differing means this is the DEBOUNCE_CYCLES-th differing clock.
    always_comb begin
        differ_s = (sync2_r != acc_r);
        accept_s = differ_s && (cnt_r == CNT_LAST);
    end

    // Stability counter, accepted level and edge pulses; any bounce back restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            acc_r     <= KEY_RELEASED;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r     <= {CW{1'b0}};
            acc_r     <= sync2_r;
            level_r   <= (sync2_r == KEY_PRESSED);
            press_r   <= (sync2_r == KEY_PRESSED);
            release_r <= (sync2_r == KEY_RELEASED);
        end else if (differ_s) begin
            cnt_r     <= cnt_r + CNT_ONE;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            cnt_r     <= {CW{1'b0}};
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end
    end

    assign key_level   = level_r;
    assign key_press   = press_r;
    assign key_release = release_r;

`ifdef KEY_LONGPRESS_EN
    localparam int            HW        = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [HW-1:0] hold_r;
    logic          long_r;

    // Hold timer: counts while pressed, saturates so the pulse fires once per press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= {HW{1'b0}};
            long_r <= 1'b0;
        end else if (level_r) begin
            if (hold_r != HOLD_MAX) begin
                hold_r <= hold_r + HOLD_ONE;
            end else begin
                hold_r <= hold_r;
            end
            long_r <= (hold_r == HOLD_LAST);
        end else begin
            hold_r <= {HW{1'b0}};
            long_r <= 1'b0;
        end
    end

    assign key_long = long_r;
`else
    logic [31:0] unused_long_s;
    assign unused_long_s = 32'(LONG_CYCLES);
    assign key_long      = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS independent push-button debouncers.
// Optional feature: define KEY_LONGPRESS_EN to enable the per-key long-press
// pulse on key_long; otherwise key_long is tied to 0.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = DEFAULT_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave bus
);

    logic [N_KEYS-1:0] level_s;
    logic [N_KEYS-1:0] press_s;
    logic [N_KEYS-1:0] release_s;
    logic [N_KEYS-1:0] long_s;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_pin     (bus.key[gi]),
            .key_level   (level_s[gi]),
            .key_press   (press_s[gi]),
            .key_release (release_s[gi]),
            .key_long    (long_s[gi])
        );
    end

    assign bus.key_level   = level_s;
    assign bus.key_press   = press_s;
    assign bus.key_release = release_s;
    assign bus.key_long    = long_s;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table-driven and randomized check of key_debounce with
// DEBOUNCE_CYCLES=16 and LONG_CYCLES=64. The reference model decides each
// acceptance by looking at a window of the raw pin samples seen two clocks
// earlier, and times long presses from the cycle the press was accepted.
module tb_key_debounce;

    localparam int NK = 4;
    localparam int DC = 16;
    localparam int LC = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    key_debounce_if #(.N_KEYS(NK)) bus ();

    key_debounce #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [NK-1:0] q [$];
    logic [NK-1:0] m_level, m_press, m_rel, m_long;
    int            cyc = 0;
    int            press_cyc [NK];

    // pulses observed during a stretch of ticks
    logic [NK-1:0] seen_press, seen_rel, seen_long;

    typedef struct {
        logic [NK-1:0] key;
        int            cycles;
        logic [NK-1:0] exp_level;
        logic [NK-1:0] exp_press;
        logic [NK-1:0] exp_rel;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        repeat (DC + 1) q.push_back({NK{1'b1}});
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int c = 0; c < NK; c++) press_cyc[c] = -100000;
    endtask

    task automatic model_edge(input logic [NK-1:0] raw);
        logic [NK-1:0] was_level;
        bit            all_diff;
        was_level = m_level;
        cyc++;
        for (int ch = 0; ch < NK; ch++) begin
            all_diff = 1'b1;
            for (int i = 0; i < DC; i++) begin
                if ((q[i][ch] == 1'b0) == was_level[ch]) all_diff = 1'b0;
            end
            m_press[ch] = 1'b0;
            m_rel[ch]   = 1'b0;
            m_long[ch]  = 1'b0;
            if (all_diff) begin
                m_level[ch] = ~was_level[ch];
                if (m_level[ch]) begin
                    m_press[ch]   = 1'b1;
                    press_cyc[ch] = cyc;
                end else begin
                    m_rel[ch] = 1'b1;
                end
            end
`ifdef KEY_LONGPRESS_EN
            if (was_level[ch] && (cyc == press_cyc[ch] + LC)) m_long[ch] = 1'b1;
`endif
        end
        q.push_back(raw);
        void'(q.pop_front());
    endtask

    // one clock: drive at the falling edge, model at the rising edge, compare 1 ns later
    task automatic tick(input logic [NK-1:0] raw);
        bus.key = raw;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(raw);
        #1;
        check("key_level",   bus.key_level,   m_level);
        check("key_press",   bus.key_press,   m_press);
        check("key_release", bus.key_release, m_rel);
        check("key_long",    bus.key_long,    m_long);
        seen_press |= bus.key_press;
        seen_rel   |= bus.key_release;
        seen_long  |= bus.key_long;
        @(negedge clk);
    endtask

    initial begin
        int            press_at, n_press, long_at, n_long;
        int            rate;
        logic [NK-1:0] cur;

        tbl[0] = '{4'hF, 20, 4'h0, 4'h0, 4'h0};
        tbl[1] = '{4'hE, 17, 4'h0, 4'h0, 4'h0};   // one clock short of acceptance
        tbl[2] = '{4'hE,  1, 4'h1, 4'h1, 4'h0};   // 18th clock: press accepted
        tbl[3] = '{4'hE, 40, 4'h1, 4'h0, 4'h0};
        tbl[4] = '{4'hF, 17, 4'h1, 4'h0, 4'h0};
        tbl[5] = '{4'hF,  1, 4'h0, 4'h0, 4'h1};   // release at +18
        tbl[6] = '{4'h0, 18, 4'hF, 4'hF, 4'h0};   // all keys together
        tbl[7] = '{4'hF, 18, 4'h0, 4'h0, 4'hF};

        model_reset();
        bus.key = {NK{1'b1}};

        // reset state
        rst = 1'b1;
        repeat (3) tick(4'hF);
        rst = 1'b0;

        // table-driven vectors
        for (int r = 0; r < 8; r++) begin
            seen_press = '0;
            seen_rel   = '0;
            seen_long  = '0;
            for (int c = 0; c < tbl[r].cycles; c++) tick(tbl[r].key);
            check($sformatf("tbl%0d_level", r), bus.key_level, tbl[r].exp_level);
            check($sformatf("tbl%0d_press", r), seen_press, tbl[r].exp_press);
            check($sformatf("tbl%0d_rel", r),   seen_rel,   tbl[r].exp_rel);
        end

        // bounce rejection on key[1]
        seen_press = '0;
        seen_rel   = '0;
        for (int r = 0; r < 5; r++) begin
            repeat (10) tick(4'hD);
            repeat (10) tick(4'hF);
        end
        repeat (20) tick(4'hF);
        check("bounce_level", bus.key_level, 4'h0);
        check("bounce_press", seen_press, 4'h0);
        check("bounce_rel",   seen_rel,   4'h0);

        // reset mid-count: key[3] already accepted, key[0] 8 clocks into its count
        repeat (20) tick(4'h7);
        check("pre_rst_level", bus.key_level, 4'h8);
        repeat (8) tick(4'h6);
        rst = 1'b1;
        #1;
        check("rst_async_level", bus.key_level, 4'h0);
        repeat (3) tick(4'h6);
        check("rst_level", bus.key_level, 4'h0);
        rst      = 1'b0;
        press_at = -1;
        n_press  = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(4'h6);
            if (bus.key_press[0]) begin
                n_press++;
                if (press_at < 0) press_at = i;
            end
        end
        check("rst_press_delay", press_at, 18);
        check("rst_press_count", n_press, 1);

        // long press on key[2]
        repeat (25) tick(4'hF);
        press_at = -1;
        long_at  = -1;
        n_long   = 0;
        for (int i = 1; i <= 200; i++) begin
            tick(4'hB);
            if (bus.key_press[2] && press_at < 0) press_at = i;
            if (bus.key_long[2]) begin
                n_long++;
                if (long_at < 0) long_at = i;
            end
        end
        check("long_press_at", press_at, 18);
`ifdef KEY_LONGPRESS_EN
        check("long_count", n_long, 1);
        check("long_delay", long_at - press_at, LC);
`else
        check("long_count", n_long, 0);
`endif
        repeat (25) tick(4'hF);

        // randomized bouncing against the reference model
        cur = 4'hF;
        for (int blk = 0; blk < 6; blk++) begin
            case (blk)
                0: rate = 3;
                1: rate = 40;
                2: rate = 10;
                3: rate = 80;
                4: rate = 5;
                default: rate = 60;
            endcase
            if (blk == 3) begin
                rst = 1'b1;
                repeat (2) tick(cur);
                rst = 1'b0;
            end
            for (int c = 0; c < 500; c++) begin
                for (int ch = 0; ch < NK; ch++) begin
                    if ($urandom_range(rate - 1, 0) == 0) cur[ch] = ~cur[ch];
                end
                tick(cur);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
